fir_out_fifo: RTL and testbench
===============================

// Module: fir_out_fifo
// PURPOSE
//  Output buffer directly downstream of the FIR engine's AXI-Stream master (sm_*): absorbs FIR
//  results so short sm_tready stalls never hold off the tap/data pipeline. First-word-fall-through
//  FIFO carrying tdata+tlast, with occupancy, frame counter and a frame-done pulse for the
//  AXI-Lite status logic.
// PARAMETERS
//  pDATA_WIDTH   32   stream data width
//  pDEPTH        16   FIFO entries; power of two, >= 2
//  pLVL_W        5    occupancy width = log2(pDEPTH)+1
// PORTS
//  axis_clk    in   1            clock
//  axis_rst_n  in   1            async active-low reset
//  clr         in   1            sync flush (pulse), e.g. on ap_start
//  s_tvalid    in   1            from FIR sm_tvalid
//  s_tdata     in   pDATA_WIDTH  from FIR sm_tdata
//  s_tlast     in   1            from FIR sm_tlast
//  s_tready    out  1            to FIR sm_tready
//  m_tvalid    out  1            downstream valid
//  m_tdata     out  pDATA_WIDTH  downstream data
//  m_tlast     out  1            downstream last
//  m_tready    in   1            downstream ready
//  cfg_shift   in   5            output right-shift amount (used only with FIR_OUT_SCALE_EN)
//  level       out  pLVL_W       current occupancy 0..pDEPTH
//  frame_cnt   out  32           frames (tlast beats) delivered on m_* since reset/clr
//  frame_done  out  1            1-cycle pulse after a tlast beat is accepted on m_*
// BEHAVIOUR
//  - Reset axis_rst_n, asynchronous, active-low; clock axis_clk. All state on axis_clk.
//  - Reset values: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, level=0, frame_cnt=0, frame_done=0.
//  - Storage: pDEPTH x (pDATA_WIDTH+1) regs; wr_ptr/rd_ptr log2(pDEPTH) bits, wrap mod pDEPTH.
//  - push = s_tvalid & s_tready; pop = m_tvalid & m_tready. level += push - pop each cycle.
//  - s_tready registered: next = !clr & (level_next < pDEPTH); 1st cycle after reset release = 1.
//    Full => s_tready=0 that cycle; pop on a full cycle re-raises s_tready the following cycle.
//  - m_tvalid = (level != 0); m_tdata/m_tlast = head entry (FWFT, comb from storage).
//  - Latency: beat pushed in cycle N is presented on m_* in cycle N+1 (empty FIFO case).
//  - Simultaneous push+pop: level unchanged, both pointers advance; legal at empty only if
//    level==0 means no pop, so push alone occurs.
//  - m_tdata/m_tlast held stable while m_tvalid & !m_tready (AXIS rule); never drop or duplicate.
//  - frame_done registered: 1 in cycle after pop with m_tlast=1; frame_cnt increments same edge,
//    wraps 2^32-1 -> 0.
//  - clr (sync): ptrs, level, frame_cnt -> 0, frame_done -> 0, push/pop that cycle ignored,
//    s_tready=0 next cycle. clr wins over every other event.
//  - Async reset mid-stream: contents discarded, all outputs to reset values immediately.
// CONFIGURATION
//  - FIR_OUT_SCALE_EN defined: m_tdata = head_data >>> cfg_shift (arithmetic), rounded half-up:
//    add (1<<(cfg_shift-1)) before shift when cfg_shift != 0; add done in pDATA_WIDTH+1 bits,
//    saturate to 0x7FFF_FFFF on positive overflow. Comb on read path; latency unchanged.
//  - Undefined: m_tdata = head_data unmodified; cfg_shift ignored (unconnected legal).
// TESTING
//  - Reset release, m_tready=1, push 0x5,0x7,0x9(tlast) -> m_* same order, 1 cycle later each;
//    frame_done pulses once; frame_cnt=1.
//  - m_tready=0, push 16 beats -> level=16, s_tready=0 next cycle; 17th s_tvalid not taken;
//    one pop -> s_tready=1 following cycle; all 16 drained in order, no loss.
//  - Full FIFO, push+pop every cycle for 100 cycles with random m_tready -> data order preserved,
//    level never exceeds 16 nor underflows.
//  - level=5, frame_cnt=3, assert clr with s_tvalid=1 -> level=0, frame_cnt=0, m_tvalid=0,
//    pushed beat discarded.
//  - FIR_OUT_SCALE_EN, cfg_shift=2: push 0x0000_0006 -> 0x2; push 0xFFFF_FFF9 (-7) -> 0xFFFF_FFFE;
//    push 0x7FFF_FFFF, cfg_shift=1 -> 0x4000_0000. Without macro same inputs pass unchanged.
//  - Async reset asserted with level=8 mid-frame -> all outputs reset values in same cycle.

Source files
------------

// File: rtl/fir_out_fifo.sv
// First-word-fall-through output FIFO behind the FIR stream master, with occupancy and frame status.
// Optional read-path rounding/scaling is enabled by defining FIR_OUT_SCALE_EN.
`timescale 1ns/1ps
module fir_out_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16,
    parameter int pLVL_W      = 5
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   clr,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic [4:0]             cfg_shift,
    output logic [pLVL_W-1:0]      level,
    output logic [31:0]            frame_cnt,
    output logic                   frame_done
);

    localparam int                PTR_W   = $clog2(pDEPTH);
    localparam logic [pLVL_W-1:0] DEPTH_L = pLVL_W'(pDEPTH);

    logic [pDATA_WIDTH:0]          mem [pDEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [pLVL_W-1:0]             level_next;
    logic                          push;
    logic                          pop;
    logic signed [pDATA_WIDTH-1:0] head_data;
    logic                          head_last;

    assign push     = s_tvalid & s_tready;
    assign m_tvalid = (level != '0);
    assign pop      = m_tvalid & m_tready;
    assign {head_last, head_data} = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // Storage is data only: never reset, written solely on an accepted beat.
    always_ff @(posedge axis_clk) begin
        if (push && !clr)
            mem[wr_ptr] <= {s_tlast, s_tdata};
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            s_tready   <= 1'b0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            s_tready   <= 1'b0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level      <= level_next;
            // Registered ready: drops in the same cycle the FIFO becomes full.
            s_tready   <= (level_next < DEPTH_L);
            frame_done <= pop & m_tlast;
            if (pop && m_tlast)
                frame_cnt <= frame_cnt + 32'd1;
        end
    end

    // Head is gated by m_tvalid so the outputs read zero while empty or in reset.
    assign m_tlast = m_tvalid & head_last;

`ifdef FIR_OUT_SCALE_EN
    function automatic logic signed [pDATA_WIDTH-1:0] round_sat(
        input logic signed [pDATA_WIDTH-1:0] d,
        input logic [4:0]                    sh
    );
        logic signed [pDATA_WIDTH:0] sum;
        logic signed [pDATA_WIDTH:0] rnd;
        logic signed [pDATA_WIDTH:0] shifted;
        logic signed [pDATA_WIDTH:0] max_pos;
        max_pos = {2'b00, {(pDATA_WIDTH-1){1'b1}}};
        sum     = {d[pDATA_WIDTH-1], d};
        rnd     = '0;
        if (sh != 5'd0)
            rnd = (pDATA_WIDTH+1)'(1) << (sh - 5'd1);
        sum     = sum + rnd;
        shifted = sum >>> sh;
        if (shifted > max_pos)
            return max_pos[pDATA_WIDTH-1:0];
        return shifted[pDATA_WIDTH-1:0];
    endfunction

    assign m_tdata = m_tvalid ? round_sat(head_data, cfg_shift) : '0;
`else
    logic unused_cfg_shift;
    assign unused_cfg_shift = ^cfg_shift;
    assign m_tdata = m_tvalid ? head_data : '0;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed self-checking bench for fir_out_fifo (default build and FIR_OUT_SCALE_EN build).
`timescale 1ns/1ps
module tb_fir_out_fifo;

    logic        axis_clk   = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        clr        = 1'b0;
    logic        s_tvalid   = 1'b0;
    logic [31:0] s_tdata    = '0;
    logic        s_tlast    = 1'b0;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready   = 1'b0;
    logic [4:0]  cfg_shift  = '0;
    logic [4:0]  level;
    logic [31:0] frame_cnt;
    logic        frame_done;

    int n_pass  = 0;
    int n_total = 0;

    fir_out_fifo #(.pDATA_WIDTH(32), .pDEPTH(16), .pLVL_W(5)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .clr        (clr),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .cfg_shift  (cfg_shift),
        .level      (level),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done)
    );

    always #5 axis_clk = ~axis_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge axis_clk);
        #1;
    endtask

    task automatic scale_one(input string tag, input logic [31:0] d, input logic [4:0] sh,
                             input logic [31:0] exp_scaled);
        cfg_shift = sh;
        m_tready  = 1'b0;
        s_tvalid  = 1'b1;
        s_tdata   = d;
        tick();
        s_tvalid  = 1'b0;
`ifdef FIR_OUT_SCALE_EN
        check(tag, m_tdata, exp_scaled);
`else
        check(tag, m_tdata, d);
`endif
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
    endtask

    logic [31:0] q[$];
    logic        exp_rdy;
    logic        mr;
    logic        do_pop;
    logic [31:0] seq;

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_level", level, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_frame_done", frame_done, 0);

        // Basic frame 5,7,9(tlast)
        axis_rst_n = 1'b1;
        m_tready   = 1'b1;
        tick();
        check("rel_s_tready", s_tready, 1);
        s_tvalid = 1'b1; s_tdata = 32'h5;
        tick();
        check("b0_valid", m_tvalid, 1);
        check("b0_data", m_tdata, 32'h5);
        s_tdata = 32'h7;
        tick();
        check("b1_data", m_tdata, 32'h7);
        check("b1_level", level, 1);
        s_tdata = 32'h9; s_tlast = 1'b1;
        tick();
        check("b2_data", m_tdata, 32'h9);
        check("b2_last", m_tlast, 1);
        check("b2_fdone", frame_done, 0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        tick();
        check("f1_valid", m_tvalid, 0);
        check("f1_fdone", frame_done, 1);
        check("f1_fcnt", frame_cnt, 1);
        tick();
        check("f1_fdone_clear", frame_done, 0);

        // Fill to full with the sink stalled
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 32'h100 + i;
            tick();
            check("fill_level", level, i + 1);
        end
        check("full_s_tready", s_tready, 0);
        s_tdata = 32'hDEAD;
        tick();
        check("full_17th_level", level, 16);
        check("full_hold_data", m_tdata, 32'h100);
        m_tready = 1'b1;
        tick();
        check("pop1_level", level, 15);
        check("pop1_s_tready", s_tready, 1);
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        check("pop1_head", m_tdata, 32'h101);
        m_tready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("drain_data", m_tdata, 32'h100 + i);
            tick();
        end
        check("drain_level", level, 0);
        check("drain_valid", m_tvalid, 0);

        // Full FIFO with random sink backpressure
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        seq      = 32'hA000_0000;
        exp_rdy  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_tdata = seq;
            tick();
            q.push_back(seq);
            seq++;
        end
        exp_rdy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            mr       = 1'($urandom_range(0, 1));
            m_tready = mr;
            s_tdata  = seq;
            do_pop   = mr && (q.size() > 0);
            if (q.size() > 0)
                check("rand_head", m_tdata, q[0]);
            tick();
            if (do_pop)
                void'(q.pop_front());
            if (exp_rdy) begin
                q.push_back(seq);
                seq++;
            end
            exp_rdy = (q.size() < 16);
            check("rand_level", level, q.size());
            check("rand_s_tready", s_tready, exp_rdy);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            check("rand_drain", m_tdata, q[0]);
            tick();
            void'(q.pop_front());
        end
        check("rand_empty", level, 0);

        // Two more frames, then partial fill and flush
        s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 32'hAA;
        tick();
        s_tdata = 32'hBB;
        tick();
        s_tvalid = 1'b0;
        tick();
        check("pre_clr_fcnt", frame_cnt, 3);
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = 32'h200 + i;
            tick();
        end
        check("pre_clr_level", level, 5);
        clr = 1'b1; s_tdata = 32'hBAD;
        tick();
        clr = 1'b0; s_tvalid = 1'b0;
        check("clr_level", level, 0);
        check("clr_fcnt", frame_cnt, 0);
        check("clr_valid", m_tvalid, 0);
        check("clr_s_tready", s_tready, 0);
        check("clr_fdone", frame_done, 0);
        tick();
        check("post_clr_s_tready", s_tready, 1);
        check("post_clr_level", level, 0);
        check("post_clr_valid", m_tvalid, 0);

        // Read-path scaling (pass-through in the default build)
        scale_one("scale_pos", 32'h0000_0006, 5'd2, 32'h0000_0002);
        scale_one("scale_neg", 32'hFFFF_FFF9, 5'd2, 32'hFFFF_FFFE);
        scale_one("scale_max", 32'h7FFF_FFFF, 5'd1, 32'h4000_0000);
        cfg_shift = 5'd0;
        check("scale_empty", level, 0);

        // Async reset mid-frame with 8 beats queued
        m_tready = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 32'h2FF;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        tick();
        check("ar_pre_fcnt", frame_cnt, 1);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_tdata = 32'h300 + i;
            tick();
        end
        s_tvalid = 1'b0;
        check("ar_pre_level", level, 8);
        check("ar_pre_valid", m_tvalid, 1);
        #2;
        axis_rst_n = 1'b0;
        #1;
        check("ar_s_tready", s_tready, 0);
        check("ar_m_tvalid", m_tvalid, 0);
        check("ar_m_tdata", m_tdata, 0);
        check("ar_m_tlast", m_tlast, 0);
        check("ar_level", level, 0);
        check("ar_fcnt", frame_cnt, 0);
        check("ar_fdone", frame_done, 0);
        tick();
        axis_rst_n = 1'b1;
        tick();
        check("ar_rel_s_tready", s_tready, 1);
        check("ar_rel_valid", m_tvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
